// File: rtl/booth_divider_seq.sv
// booth_divider_seq: sequential signed divider, 2N-bit dividend by N-bit divisor,
// restoring magnitude division with sign correction, truncation toward zero.
// Ports:
//   CLK, RST        rising-edge clock, asynchronous active-high reset
//   START           request pulse, only sampled in IDLE (ignored while BUSY)
//   DIVIDEND        2N-bit signed dividend, captured on the accepting edge
//   DIVISOR         N-bit signed divisor, captured with DIVIDEND
//   QUOT, REM       N-bit signed quotient / remainder, registered
//   ERR             divide-by-zero or quotient overflow, registered
//   BUSY            high from the accepting edge until DONE
//   DONE            one-cycle completion pulse (N+3 edges normal, 2 edges on error)
module booth_divider_seq #(
   parameter int N = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic [2*N-1:0] DIVIDEND,
   input  logic [N-1:0]   DIVISOR,
   output logic [N-1:0]   QUOT,
   output logic [N-1:0]   REM,
   output logic           ERR,
   output logic           BUSY,
   output logic           DONE
);

   localparam int W  = 2 * N + 1;        // partial-remainder/quotient register width
   localparam int CW = $clog2(N + 1);    // iteration counter must hold N

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_DIV,
      S_FIX,
      S_FIN
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    pr;       // {partial remainder (N+1), dividend/quotient bits (N)}
   logic [N-1:0]    ds_mag;
   logic            sgn_dd;
   logic            sgn_ds;

   logic [2*N-1:0]  dd_abs;
   logic [N-1:0]    ds_abs;
   logic [W-1:0]    lim_eq;
   logic [W-1:0]    lim_ne;
   logic            div_err;
   logic [W-1:0]    pr_sh;
   logic [N+1:0]    diff;
   logic [W-1:0]    pr_next;
   logic [N-1:0]    q_mag;
   logic [N-1:0]    r_mag;

   // Magnitudes as unsigned values: the most negative input still fits
   // (e.g. -128 becomes 8'h80 interpreted unsigned).
   always_comb begin
      dd_abs = DIVIDEND[2*N-1] ? -DIVIDEND : DIVIDEND;
      ds_abs = DIVISOR[N-1]    ? -DIVISOR  : DIVISOR;
   end

   // Overflow bounds: a same-sign quotient must stay below 2^(N-1); an
   // opposite-sign quotient may reach exactly -2^(N-1), hence the +|divisor|.
   always_comb begin
      lim_eq  = W'(ds_mag) << (N - 1);
      lim_ne  = lim_eq + W'(ds_mag);
      div_err = (ds_mag == '0) ||
                ((sgn_dd == sgn_ds) ? (pr >= lim_eq) : (pr >= lim_ne));
   end

   // One restoring step. With no overflow the top N dividend bits are
   // already below |divisor|, so N steps yield the full quotient and the
   // (N+1)-bit upper field never overflows.
   always_comb begin
      pr_sh   = {pr[W-2:0], 1'b0};
      diff    = {1'b0, pr_sh[W-1:N]} - {2'b00, ds_mag};
      pr_next = pr_sh;
      if (!diff[N+1])
         pr_next = {diff[N:0], pr_sh[N-1:1], 1'b1};
      q_mag   = pr[N-1:0];
      r_mag   = pr[2*N-1:N];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= S_IDLE;
         cnt    <= '0;
         pr     <= '0;
         ds_mag <= '0;
         sgn_dd <= 1'b0;
         sgn_ds <= 1'b0;
         QUOT   <= '0;
         REM    <= '0;
         ERR    <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  pr     <= {1'b0, dd_abs};
                  ds_mag <= ds_abs;
                  sgn_dd <= DIVIDEND[2*N-1];
                  sgn_ds <= DIVISOR[N-1];
                  ERR    <= 1'b0;
                  BUSY   <= 1'b1;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (div_err) begin
                  ERR   <= 1'b1;
                  QUOT  <= '0;
                  REM   <= '0;
                  state <= S_FIN;
               end else begin
                  cnt   <= CW'(N);
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               pr  <= pr_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= S_FIX;
            end
            S_FIX: begin
               // Quotient truncates toward zero; remainder follows the dividend.
               QUOT  <= (sgn_dd ^ sgn_ds) ? -q_mag : q_mag;
               REM   <= sgn_dd ? -r_mag : r_mag;
               ERR   <= 1'b0;
               state <= S_FIN;
            end
            S_FIN: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed bench for booth_divider_seq (N=4): driver pushes hand-computed
// results into a scoreboard queue; a monitor pops and compares on each DONE.
module tb_booth_divider_seq;

   localparam int N = 4;

   logic           CLK;
   logic           RST;
   logic           START;
   logic [2*N-1:0] DIVIDEND;
   logic [N-1:0]   DIVISOR;
   logic [N-1:0]   QUOT;
   logic [N-1:0]   REM;
   logic           ERR;
   logic           BUSY;
   logic           DONE;

   booth_divider_seq #(.N(N)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .QUOT     (QUOT),
      .REM      (REM),
      .ERR      (ERR),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         e;
      int           cyc;   // posedge count at which DONE must be registered
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   total  = 0;
   int   passed = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compare every DONE pulse against the oldest expectation.
   always @(negedge CLK) begin
      if (!RST && DONE) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: DONE high with no pending operation (cycle %0d)", cyc);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk({x.tag, "_quot"},  QUOT, x.q);
            chk({x.tag, "_rem"},   REM,  x.r);
            chk({x.tag, "_err"},   ERR,  x.e);
            chk({x.tag, "_latency"}, cyc, x.cyc);
         end
      end
   end

   task automatic push_exp(input string tag, input int q, input int r, input bit e, input int done_cyc);
      exp_t x;
      x.q = N'(q);
      x.r = N'(r);
      x.e = e;
      x.cyc = done_cyc;
      x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(posedge CLK);
      end
      if (sb.size() != 0) begin
         total++;
         $display("FAIL %s_timeout: %0d result(s) still pending, expected 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_op(input string tag, input int dd, input int ds,
                        input int q, input int r, input bit e, input int lat);
      @(negedge CLK);
      DIVIDEND = (2*N)'(dd);
      DIVISOR  = N'(ds);
      START    = 1'b1;
      push_exp(tag, q, r, e, cyc + 1 + lat);
      @(negedge CLK);
      START = 1'b0;
      chk({tag, "_busy"}, BUSY, 1);
      chk({tag, "_errclr"}, ERR, 0);
      wait_drain(tag);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   initial begin
      int c0;
      RST      = 1'b1;
      START    = 1'b0;
      DIVIDEND = '0;
      DIVISOR  = '0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", {QUOT, REM, ERR, BUSY, DONE}, 0);
      RST = 1'b0;

      // name, dividend, divisor, quot, rem, err, latency
      do_op("4_div_2",      4,    2,  2,  0, 1'b0, 7);
      do_op("m13_div_4",  -13,    4, -3, -1, 1'b0, 7);
      do_op("13_div_m4",   13,   -4, -3,  1, 1'b0, 7);
      do_op("56_div_7",    56,    7,  0,  0, 1'b1, 2);
      do_op("m56_div_7",  -56,    7, -8,  0, 1'b0, 7);
      do_op("49_div_7",    49,    7,  7,  0, 1'b0, 7);
      do_op("100_div_0",  100,    0,  0,  0, 1'b1, 2);
      do_op("m5_div_0",    -5,    0,  0,  0, 1'b1, 2);
      do_op("m128_div_m1",-128,  -1,  0,  0, 1'b1, 2);
      do_op("m64_div_m8", -64,   -8,  0,  0, 1'b1, 2);
      do_op("m63_div_m8", -63,   -8,  7, -7, 1'b0, 7);
      do_op("64_div_m8",   64,   -8, -8,  0, 1'b0, 7);

      // Back-to-back: 9/3 accepted at c0+1, ignored pulse mid-DIV, then START
      // held so 30/6 is taken on the edge after FIN (c0+1+N+4).
      @(negedge CLK);
      c0 = cyc;
      DIVIDEND = 8'd9;
      DIVISOR  = 4'd3;
      START    = 1'b1;
      push_exp("b2b_9_div_3", 3, 0, 1'b0, c0 + 1 + 7);
      push_exp("b2b_30_div_6", 5, 0, 1'b0, c0 + 1 + 8 + 7);
      @(negedge CLK);
      START = 1'b0;
      wait_until(c0 + 3);
      DIVIDEND = 8'd30;
      DIVISOR  = 4'd6;
      START    = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_until(c0 + 5);
      START = 1'b1;
      wait_until(c0 + 9);
      START = 1'b0;
      wait_drain("b2b");

      // Reset during the second DIV cycle: outputs clear at once, no DONE.
      @(negedge CLK);
      c0 = cyc;
      DIVIDEND = 8'd9;
      DIVISOR  = 4'd3;
      START    = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_until(c0 + 3);
      RST = 1'b1;
      #1;
      chk("midop_reset_outputs", {QUOT, REM, ERR, BUSY, DONE}, 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (12) @(negedge CLK);
      chk("midop_reset_idle", {BUSY, DONE}, 0);

      do_op("20_div_5", 20, 5, 4, 0, 1'b0, 7);

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed divider that inverts the Booth multiplier datapath.
- Takes a 2N-bit signed dividend, the same width as the multiplier PRODUCT, and an N-bit signed divisor.
- Returns an N-bit quotient and an N-bit remainder after a fixed number of clocks.
- Sits beside the multiplier in the arithmetic unit and is used for product-check and scaling paths.

Parameters:
- N, 4, operand width. Divisor, quotient and remainder are N bits; the dividend is 2N bits. Legal range N >= 2.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- START  input  1  request pulse; sampled only in IDLE
- DIVIDEND  input  2N  signed dividend; captured on the edge that accepts START
- DIVISOR  input  N  signed divisor; captured with DIVIDEND
- QUOT  output  N  signed quotient, registered
- REM  output  N  signed remainder, registered
- ERR  output  1  divide-by-zero or quotient overflow, registered
- BUSY  output  1  high from the accepting edge until DONE
- DONE  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. While RST is high, all of the following are 0: state (IDLE), QUOT, REM, ERR, BUSY, DONE and all internal registers.
- Reset mid-operation aborts the division. No DONE is produced. The block returns to IDLE.
- States: IDLE, CHECK, DIV, FIX, FIN.
- IDLE:
  - START=1 at an edge captures the operands, latches both sign bits, forms unsigned magnitudes |DIVIDEND| (2N bits) and |DIVISOR| (N bits), sets BUSY=1, and moves to CHECK.
  - START=0 stays in IDLE.
- START while BUSY is ignored; no queuing.
- CHECK (1 cycle):
  - Error conditions:
    - Divisor == 0.
    - Signs equal and |DIVIDEND| >= |DIVISOR|*2^(N-1).
    - Signs differ and |DIVIDEND| >= |DIVISOR|*(2^(N-1)+1).
  - Any error goes to FIN with ERR=1, QUOT=0, REM=0.
  - Otherwise go to DIV with iteration counter = N.
- DIV (exactly N cycles), one restoring step per cycle on a (2N+1)-bit partial-remainder/quotient register:
  - Shift left 1.
  - Subtract |DIVISOR| from the upper part.
  - If the result is non-negative, keep it and set quotient LSB=1; else restore and set LSB=0.
  - Decrement the counter; at 0 go to FIX.
- FIX (1 cycle): apply signs.
  - Quotient is negated if the signs differ; truncation is toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: DIVIDEND == QUOT*DIVISOR + REM, with |REM| < |DIVISOR|.
  - QUOT, REM and ERR=0 are registered here. Go to FIN.
- FIN (1 cycle): DONE=1 and BUSY=0 at the end of this cycle, then return to IDLE.
- Outputs hold their values until the next accepted START. On an accepted START, ERR clears; QUOT and REM hold until overwritten.
- Latency, counted as edges after the START-accepting edge until DONE is high:
  - Normal: N+3 (7 for N=4).
  - Error: 2.
- START held continuously re-triggers in IDLE on the edge after FIN, giving a back-to-back operation every N+4 edges.
- Arithmetic: all internal magnitudes are unsigned with enough width that |-2^(2N-1)| is representable. No wrap-around is permitted in intermediate values.

Test Plan:
- N=4, DIVIDEND=4, DIVISOR=2 -> QUOT=2, REM=0, ERR=0, DONE exactly 7 edges after START, BUSY high throughout.
- DIVIDEND=-13 (8'hF3), DIVISOR=4 -> QUOT=-3 (4'hD), REM=-1 (4'hF), ERR=0. DIVIDEND=13, DIVISOR=-4 -> QUOT=-3, REM=1.
- Overflow boundary:
  - DIVIDEND=56, DIVISOR=7 -> ERR=1, QUOT=0, REM=0, DONE after 2 edges.
  - DIVIDEND=-56, DIVISOR=7 -> QUOT=-8, REM=0, ERR=0.
  - DIVIDEND=49, DIVISOR=7 -> QUOT=7, REM=0, ERR=0.
- DIVISOR=0 with any dividend -> ERR=1, QUOT=0, REM=0. DIVIDEND=-128, DIVISOR=-1 -> ERR=1.
- Back-to-back products 9/3 then 30/6 (these are the multiplier's own products), with START re-pulsed mid-operation -> the mid-operation pulse is ignored; results are 3/0 then 5/0, each with one DONE pulse.
- Assert RST during DIV cycle 2 -> all outputs 0 immediately (asynchronous), no DONE. The next START 20/5 -> QUOT=4, REM=0.
